// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared constants and state encoding for reg_file_sb
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

  // Sweep FSM encoding
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// reg_file_scoreboard : per-register busy bits, reserve set / writeback clear
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              rsv_ok
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DEPTH-1:0] w_busy;

  // A busy register may be re-reserved when its producer writes back this cycle.
  assign rsv_ok = en & rsv_valid & (~w_busy[rsv_addr] | (we & (wa == rsv_addr)));
  assign busy1  = w_busy[ra1];
  assign busy2  = w_busy[ra2];

  for (genvar i = 0; i < DEPTH; i++) begin : g_bit
    if (ZERO_REG && (i == 0)) begin : g_zero
      assign w_busy[i] = 1'b0;
    end else begin : g_reg
      logic w_set;
      logic w_clr;
      logic r_bit;

      assign w_set = rsv_ok & (rsv_addr == ADDR_W'(i));
      assign w_clr = en & we & (wa == ADDR_W'(i));

      // Set has priority so the new producer wins over a same-cycle release.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_bit <= 1'b0;
        end else if (w_set) begin
          r_bit <= 1'b1;
        end else if (w_clr) begin
          r_bit <= 1'b0;
        end
      end

      assign w_busy[i] = r_bit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// reg_file_sb : 2R/1W register file with busy scoreboard and post-reset sweep
//               Optional same-cycle write bypass enabled by RF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic              ready
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_run;
  logic              w_wr_zero;
  logic              w_z1;
  logic              w_z2;
  logic              w_sb_busy1;
  logic              w_sb_busy2;

  assign w_run     = (r_state == ST_RUN);
  assign ready     = w_run;
  assign w_wr_zero = ZERO_REG && (wa == '0);
  assign w_z1      = ZERO_REG && (ra1 == '0);
  assign w_z2      = ZERO_REG && (ra2 == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_idx <= '0;
    end else if (r_state == ST_INIT) begin
      r_clr_idx <= r_clr_idx + ADDR_W'(1);
      if (&r_clr_idx) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Storage has no reset; the sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_clr_idx] <= '0;
    end else if (we && !w_wr_zero) begin
      r_mem[wa] <= wd;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_run),
    .we        (we),
    .wa        (wa),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (w_sb_busy1),
    .busy2     (w_sb_busy2),
    .rsv_ok    (rsv_ok)
  );

`ifdef RF_BYPASS_EN
  logic w_byp1;
  logic w_byp2;
  assign w_byp1 = we && (wa == ra1);
  assign w_byp2 = we && (wa == ra2);
`endif

  always_comb begin
    rd1   = r_mem[ra1];
    busy1 = w_sb_busy1;
`ifdef RF_BYPASS_EN
    if (w_byp1) begin
      rd1   = wd;
      busy1 = rsv_ok && (rsv_addr == ra1);
    end
`endif
    if (!w_run || w_z1) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
  end

  always_comb begin
    rd2   = r_mem[ra2];
    busy2 = w_sb_busy2;
`ifdef RF_BYPASS_EN
    if (w_byp2) begin
      rd2   = wd;
      busy2 = rsv_ok && (rsv_addr == ra2);
    end
`endif
    if (!w_run || w_z2) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// tb_reg_file_sb : randomized scoreboard bench for reg_file_sb (32 x 32, r0 = 0)
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        busy1;
  logic        busy2;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic        ready;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic        ok;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_cnt = 0;
  bit          byp;

  initial begin
`ifdef RF_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: expected outputs for this cycle, then the state after the edge.
  task automatic cyc(input bit rn, input bit w, input logic [4:0] a, input logic [31:0] d,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input bit rv, input logic [4:0] ra);
    exp_t e;
    bit   rdy;
    @(posedge clk);
    #1;
    rst_n = rn; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; rsv_valid = rv; rsv_addr = ra;
    rdy = rn && (m_cnt >= 32);
    e.rdy = rdy; e.r1 = '0; e.r2 = '0; e.b1 = 1'b0; e.b2 = 1'b0; e.ok = 1'b0;
    if (rdy) begin
      e.ok = rv && ((ra == 0) || !m_busy[ra] || (w && a == ra));
      if (r1 != 0) begin
        e.r1 = m_mem[r1];
        e.b1 = m_busy[r1];
        if (byp && w && a == r1) begin
          e.r1 = d;
          e.b1 = e.ok && (ra == r1);
        end
      end
      if (r2 != 0) begin
        e.r2 = m_mem[r2];
        e.b2 = m_busy[r2];
        if (byp && w && a == r2) begin
          e.r2 = d;
          e.b2 = e.ok && (ra == r2);
        end
      end
    end
    q.push_back(e);
    if (!rn) begin
      m_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (rdy) begin
        if (w && a != 0) begin
          m_mem[a]  = d;
          m_busy[a] = 1'b0;
        end
        if (e.ok && ra != 0) m_busy[ra] = 1'b1;
      end
      if (m_cnt < 1000) m_cnt++;
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, r1, r2, 1'b0, 5'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ready",  {31'd0, ready},  {31'd0, e.rdy});
        chk("rd1",    rd1,             e.r1);
        chk("rd2",    rd2,             e.r2);
        chk("busy1",  {31'd0, busy1},  {31'd0, e.b1});
        chk("busy2",  {31'd0, busy2},  {31'd0, e.b2});
        chk("rsv_ok", {31'd0, rsv_ok}, {31'd0, e.ok});
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0; m_busy[i] = 1'b0;
    end

    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    // Sweep with traffic offered; none of it may take effect.
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b1, 5'(i), $urandom, 5'(i), 5'(31 - i), 1'b1, 5'(i));
    for (int i = 0; i < 32; i += 2) idle(5'(i), 5'(i + 1));

    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
    idle(5'd5, 5'd5);
    cyc(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd7, 32'h00001234, 5'd0, 5'd7, 1'b0, 5'd0);
    idle(5'd7, 5'd7);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 5'd3);
    cyc(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0, 5'd0);
    idle(5'd3, 5'd3);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1, 5'd3);
    cyc(1'b1, 1'b1, 5'd3, 32'h66, 5'd3, 5'd3, 1'b1, 5'd3);
    idle(5'd3, 5'd3);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0);

    // Reset mid-RUN with r3 busy, then a full sweep with traffic offered.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd5, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b1, 5'($urandom_range(0, 31)), $urandom, 5'd3, 5'd5, 1'b1, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 32; i += 2) idle(5'(i), 5'(i + 1));

    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a, r1, r2, ra;
      bit         full;
      full = ($urandom_range(0, 3) == 0);
      a  = full ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r1 = full ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 399) != 0), 1'($urandom), a, $urandom, r1, r2, 1'($urandom), ra);
    end

    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with an integrated register scoreboard and a post-reset clear sequencer, for the pipelined CPU datapath. Two combinational read ports and one synchronous write port, plus per-register busy bits that track writes still in flight: issue reserves the destination, writeback releases it. After reset a sweep FSM zeroes the storage one entry per cycle, so the array needs no async-reset flops.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/reservations; 0 = entry 0 is an ordinary register

Ports (one clock; reset asynchronous, active-low):
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  async active-low reset
- we  in  1  write enable (writeback); also releases busy bit of wa
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- busy1, busy2  out  1  busy bit of ra1 / ra2 (combinational)
- rsv_valid  in  1  reserve request: mark rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reserve accepted this cycle (combinational)
- ready  out  1  clear sweep done; block accepts traffic

## Operation
- FSM states: INIT, RUN. Reset → INIT, clr_idx=0, all busy bits 0.
- INIT: each cycle writes 0 to entry clr_idx, clr_idx += 1; at clr_idx == DEPTH-1, after that write → RUN. we and rsv_valid ignored; rd1/rd2 forced 0, busy1/2 forced 0, rsv_ok 0, ready 0.
- RUN: ready=1. we=1 writes wd to entry wa at rising edge and clears busy[wa].
- Reserve: rsv_ok = ready & rsv_valid & (~busy[rsv_addr] | (we & wa==rsv_addr)). On rsv_ok, busy[rsv_addr] set at edge. Reserve of an already-busy register without same-cycle release: rsv_ok=0, no state change.
- Same-cycle write and accepted reserve to same address: data written, busy ends 1 (new producer wins).
- ZERO_REG=1, address 0: rd=0, busy=0, writes dropped, reserve gives rsv_ok=1 with no busy set.
- rd/busy for different addresses are independent; ra1==ra2 is legal.
- Reset asserted mid-RUN or mid-INIT: immediately INIT, ready 0, busy cleared, sweep restarts at 0. Array contents are not reset asynchronously.

## Timing
- Reset values: ready 0, rd1/rd2 0, busy1/2 0, rsv_ok 0, state INIT.
- ready rises exactly DEPTH rising edges after rst_n deasserts (DEPTH=32 → 32 cycles).
- Write latency: wd is visible on rd the cycle after the write edge (without bypass).
- Busy set latency: reserve at edge N → busy visible from cycle N+1. Release by write at edge N → busy 0 from cycle N+1 (without bypass).

## Configuration
- RF_BYPASS_EN defined: in RUN, if we & wa==raX (and not the zero register), rdX = wd and busyX = 0 in the same cycle, unless an accepted reserve targets raX that same cycle, in which case busyX = 1.
- RF_BYPASS_EN undefined: rd and busy always reflect stored state; a same-cycle write is visible one cycle later.

## Structure
- Package reg_file_pkg: state enum (INIT, RUN), default DATA_W/ADDR_W constants, DEPTH derivation.
- Sub-module reg_file_scoreboard: DEPTH busy vector with set (reserve), clear (write), two lookup ports and rsv_ok logic. The top level holds the array, the sweep FSM and the read muxes.

## Test plan
- Reset release with DATA_W=32, ADDR_W=5 → ready 0 for 32 cycles, 1 on cycle 32; every rd reads 0 afterwards.
- Write 0xDEADBEEF to r5, read ra1=5 the next cycle → rd1=0xDEADBEEF; write to r0 with ZERO_REG=1 → rd 0.
- Same-cycle write r7=0x1234 and read ra2=7 → rd2=0x1234 with RF_BYPASS_EN, old value without; next cycle both give 0x1234.
- Reserve r3 → busy1=1 for ra1=3; second reserve r3 → rsv_ok=0; write r3 → busy1 0; write + reserve r3 same cycle → rsv_ok=1 and busy stays 1.
- Assert rst_n low mid-RUN with r3 busy → busy cleared, ready 0, sweep repeats for 32 cycles; we and rsv_valid during INIT have no effect.
- During INIT, drive rsv_valid=1 and we=1 → rsv_ok 0, no busy bits set, and no stored data changed after ready.
